// File: rtl/serial_word_capture.sv
// Serial-to-parallel word capture: collects WIDTH qualified serial bits into a word
// and presents it through a one-entry valid/ready holding register with a sticky overrun flag.
module serial_word_capture #(
  parameter int unsigned WIDTH     = 4,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic                         input_clock,
  input  logic                         input_reset,
  input  logic                         input_serial_data,
  input  logic                         input_serial_valid,
  input  logic                         input_word_ready,
  output logic [WIDTH-1:0]             output_word_data,
  output logic                         output_word_valid,
  output logic [$clog2(WIDTH+1)-1:0]   output_bit_count,
  output logic                         output_overrun
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic {
    S_EMPTY = 1'b0,
    S_FULL  = 1'b1
  } state_t;

  state_t            r_state;
  logic [WIDTH-1:0]  r_collect;
  logic [WIDTH-1:0]  r_word;
  logic [CW-1:0]     r_count;
  logic              r_overrun;

  logic [WIDTH-1:0]  w_next_collect;
  logic              w_complete;

  // Shift direction decides which end of the word the first bit ends up in
  generate
    if (MSB_FIRST) begin : g_msb_first
      assign w_next_collect = {r_collect[WIDTH-2:0], input_serial_data};
    end else begin : g_lsb_first
      assign w_next_collect = {input_serial_data, r_collect[WIDTH-1:1]};
    end
  endgenerate

  assign w_complete = input_serial_valid && (r_count == CW'(WIDTH - 1));

  always_ff @(posedge input_clock) begin
    if (input_reset) begin
      r_state   <= S_EMPTY;
      r_collect <= '0;
      r_word    <= '0;
      r_count   <= '0;
      r_overrun <= 1'b0;
    end else begin
      if (input_serial_valid) begin
        r_collect <= w_next_collect;
        r_count   <= w_complete ? '0 : r_count + CW'(1);
      end

      // Holding register: a completed word is dropped only when the held one is not leaving
      case (r_state)
        S_EMPTY: begin
          if (w_complete) begin
            r_word  <= w_next_collect;
            r_state <= S_FULL;
          end
        end
        S_FULL: begin
          if (w_complete) begin
            if (input_word_ready) begin
              r_word <= w_next_collect;
            end else begin
              r_overrun <= 1'b1;
            end
          end else if (input_word_ready) begin
            r_state <= S_EMPTY;
          end
        end
        default: r_state <= S_EMPTY;
      endcase
    end
  end

  assign output_word_data  = r_word;
  assign output_word_valid = (r_state == S_FULL);
  assign output_bit_count  = r_count;
  assign output_overrun    = r_overrun;

endmodule

// File: doc/serial_word_capture.md
SERIAL_WORD_CAPTURE -- requirements
Module: serial_word_capture

Interface
REQ-001 SHALL have parameter WIDTH, default 4, number of serial bits per captured word (legal 2..16).
REQ-002 SHALL have parameter MSB_FIRST, default 1, where 1 means the first received bit lands in word bit WIDTH-1 and 0 means it lands in bit 0.
REQ-003 SHALL have port input_clock, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port input_reset, input, 1, reset that is synchronous and active-high.
REQ-005 SHALL have port input_serial_data, input, 1, serial bit from the upstream shift chain.
REQ-006 SHALL have port input_serial_valid, input, 1, qualifies input_serial_data for the current cycle.
REQ-007 SHALL have port input_word_ready, input, 1, downstream accepts output_word_data when high with output_word_valid.
REQ-008 SHALL have port output_word_data, output, WIDTH, captured parallel word.
REQ-009 SHALL have port output_word_valid, output, 1, output_word_data holds an unaccepted word.
REQ-010 SHALL have port output_bit_count, output, clog2(WIDTH+1), bits collected toward the current partial word.
REQ-011 SHALL have port output_overrun, output, 1, sticky flag set when a completed word was dropped.

Function
REQ-012 SHALL hold an internal WIDTH-bit collect register plus a bit counter; the counter increments by 1 on each cycle with input_serial_valid=1.
REQ-013 SHALL, with MSB_FIRST=1, shift the collect register left and insert input_serial_data at bit 0 on each valid cycle; with MSB_FIRST=0, shift right and insert at bit WIDTH-1.
REQ-014 SHALL treat the valid cycle that brings the count to WIDTH as word completion: the counter wraps to 0 in that same edge, never presenting the value WIDTH.
REQ-015 SHALL implement a 2-state holding FSM: EMPTY (output_word_valid=0) and FULL (output_word_valid=1).
REQ-016 SHALL, on completion in EMPTY, load the completed word (including the bit arriving that cycle) into output_word_data and go FULL on the same edge; latency from final bit to valid is 1 clock.
REQ-017 SHALL, in FULL with input_word_ready=1 and no completion, go EMPTY on that edge; output_word_data keeps its last value.
REQ-018 SHALL, in FULL with input_word_ready=1 and completion in the same cycle, load the new word and remain FULL with no bubble and no overrun.
REQ-019 SHALL, in FULL with input_word_ready=0 and completion, keep the held word unchanged, discard the new word, set output_overrun, and still wrap the counter to 0.
REQ-020 SHALL keep output_overrun at 1 until reset; no other event clears it.
REQ-021 SHALL leave the collect register and the counter unchanged on cycles with input_serial_valid=0, so gaps of any length are tolerated.
REQ-022 SHALL ignore input_word_ready while EMPTY.
REQ-023 SHALL keep output_word_data stable whenever output_word_valid=1 and input_word_ready=0.

Reset
REQ-024 SHALL, when input_reset=1 at a rising edge, set output_word_data=0, output_word_valid=0 (EMPTY), output_bit_count=0, output_overrun=0 and the collect register to 0, overriding all other inputs that cycle.
REQ-025 SHALL discard a partial word on a mid-word reset; the next valid bit after reset release counts as bit 1 of a new word.
REQ-026 SHALL be inactive for one edge after reset release only in the sense that the first post-reset edge behaves normally; no extra wait cycles.

Verification
REQ-027 SHALL pass the basic test: WIDTH=4, MSB_FIRST=1, with valid bits 1,0,1,1 on consecutive cycles and ready=1 -> output_word_valid=1 for one cycle with output_word_data=4'b1011, and counter sequence 1,2,3,0.
REQ-028 SHALL pass the ordering test: MSB_FIRST=0 with the same bits 1,0,1,1 -> output_word_data=4'b1101.
REQ-029 SHALL pass the gap and backpressure test: bits 0,1 then 5 idle cycles then 1,0, ready=0 -> word 4'b0110, valid held steady, count frozen at 2 during the gap; raising ready clears valid next edge.
REQ-030 SHALL pass the overrun test: ready=0, send 4'b1010 then 4'b0101 -> output_word_data stays 4'b1010, output_overrun=1 after the 8th bit, count=0.
REQ-031 SHALL pass the simultaneous accept/complete test: FULL with 4'b1111, ready=1 on the cycle the 4th bit of 4'b0011 arrives -> valid stays 1, data becomes 4'b0011, overrun stays 0.
REQ-032 SHALL pass the mid-word reset test: after 3 bits, assert reset for one cycle -> all outputs 0; then bits 1,1,0,0 -> word 4'b1100.
